sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock, synchronous first-in/first-out buffer of DEPTH words, each WIDTH bits wide.
It decouples a producer and a consumer in the controller datapath, for example byte streams between the host link and the command logic.
Reads are registered: the popped word appears on read_data one clock after the read is accepted.
Full and empty status flags drive upstream and downstream flow control.

Parameters:
DEPTH, 8, number of storage entries; must be a power of two and at least 2.
WIDTH, 8, bits per data word; at least 1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
write  input  1  push request; write_data is stored if the FIFO is not full.
read  input  1  pop request; the head word is popped if the FIFO is not empty.
write_data  input  WIDTH  data to push.
full  output  1  high when DEPTH entries are stored.
empty  output  1  high when 0 entries are stored.
read_data  output  WIDTH  registered output holding the last popped word.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- State:
  - storage array of DEPTH x WIDTH;
  - write and read pointers, each log2(DEPTH)+1 bits wide (extra wrap bit);
  - read_data register.
- Reset (sampled on the rising clk edge while reset=1):
  - both pointers go to 0;
  - read_data goes to 0;
  - empty=1, full=0 from the next cycle.
  - Storage contents are not cleared.
  - Reset overrides any read or write in the same cycle, and it may be asserted mid-stream; all queued data is discarded.
- Flags:
  - combinational decode of the registered pointers only; no dependence on read/write in the current cycle;
  - empty = pointers fully equal;
  - full = low address bits equal and wrap bits differ.
- Write accept: write && !full, using the pre-edge flag.
  - On accept, mem[wptr low bits] <= write_data and wptr increments.
  - A write while full is ignored; no state changes and no error flag.
- Read accept: read && !empty, using the pre-edge flag.
  - On accept, read_data <= mem[rptr low bits] and rptr increments.
  - The word is valid on read_data after that edge (latency 1 clock).
  - A read while empty is ignored and read_data holds its previous value.
- read_data changes only on an accepted read or on reset.
- Simultaneous read and write:
  - each is accepted independently per the rules above, evaluated on pre-edge flags;
  - when neither full nor empty, both complete and the occupancy is unchanged;
  - when empty, only the write occurs (no fall-through);
  - when full, only the read occurs; the write is dropped.
- Wrap-around: pointers increment modulo 2*DEPTH, so the low bits wrap naturally at DEPTH.
- Ordering: strict FIFO; words are read in exactly the order accepted.
- No combinational path from inputs to outputs.

Decomposition:
- No shared package is needed.
- Pointer width is a local constant, $clog2(DEPTH)+1.
- One natural sub-module: fifo_mem, a DEPTH x WIDTH memory with one write port and a registered read port.
- sync_fifo keeps pointers, flags and accept logic.

Test Plan:
- Reset for 5 cycles -> empty=1, full=0, read_data=0x00.
- Push 0x70 then 0x71 (one cycle each), then read for one cycle -> read_data=0x71? No: read_data=0x70 one clock after the read edge; empty=0.
- Push 0x72, then read one cycle -> read_data=0x71; then read again -> 0x72 and empty=1.
- Push 0x00..0x07 (8 words) -> full=1 after the 8th edge. Push 0xAA while full -> ignored. Drain 8 reads -> 0x00..0x07 in order, then empty=1. A 9th read -> read_data stays 0x07.
- Wrap: push 6 words, pop 6, push 0x10..0x17, pop all -> 0x10..0x17 in order. Simultaneous read+write at occupancy 3 -> occupancy stays 3; at empty -> only the write occurs.
- Reset asserted with 4 words queued and read=1 -> next cycle empty=1, read_data=0x00; a subsequent push 0x55 then read -> 0x55.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous FIFO slice.
// The pointer width carries one extra wrap bit beyond the address bits.
package sync_fifo_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 8;

    // Address bits plus one wrap bit that separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle of the FIFO.
// The FIFO sits on the slave side; the surrounding logic drives the master side.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             write;
    logic             read;
    logic [WIDTH-1:0] write_data;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] read_data;

    modport master (
        output write,
        output read,
        output write_data,
        input  full,
        input  empty,
        input  read_data
    );

    modport slave (
        input  write,
        input  read,
        input  write_data,
        output full,
        output empty,
        output read_data
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage with one write port and a registered read port.
// Storage is never cleared; only the read register returns to zero on reset.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Read register next value: cleared by reset, loaded only on an accepted read.
    always_comb begin
        rdata_d = rdata_q;
        if (reset) begin
            rdata_d = {WIDTH{1'b0}};
        end else if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read register state.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    // Storage write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, status flags and push/pop accept logic.
// Flags decode only the registered pointers, so no input reaches an output combinationally.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    sync_fifo_if.slave  bus
);

    localparam int AW = addr_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0] wptr_d;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_d;
    logic [PW-1:0] rptr_q;

    logic          full_s;
    logic          empty_s;
    logic          wr_accept_s;
    logic          rd_accept_s;
    logic          mem_we_s;
    logic          mem_re_s;

    // Status decode and accept qualification on pre-edge flags.
    always_comb begin
        empty_s     = (wptr_q == rptr_q);
        full_s      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        wr_accept_s = bus.write && !full_s;
        rd_accept_s = bus.read && !empty_s;
        mem_we_s    = wr_accept_s && !reset;
        mem_re_s    = rd_accept_s && !reset;
    end

    // Pointer next state; reset wins over any push or pop in the same cycle.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (reset) begin
            wptr_d = {PW{1'b0}};
            rptr_d = {PW{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wptr_d = wptr_q + PW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_accept_s) begin
                rptr_d = rptr_q + PW'(1);
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // Pointer state registers.
    always_ff @(posedge clk) begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we_s),
        .waddr (wptr_q[AW-1:0]),
        .wdata (bus.write_data),
        .re    (mem_re_s),
        .raddr (rptr_q[AW-1:0]),
        .rdata (bus.read_data)
    );

    assign bus.full  = full_s;
    assign bus.empty = empty_s;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios followed by random traffic,
// compared against a queue-based model of FIFO occupancy and output register.
module tb_sync_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;

    sync_fifo_if #(.WIDTH(WIDTH)) bus ();

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] model_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic step(input logic rst, input logic w, input logic r, input logic [WIDTH-1:0] d);
        int pre_size;
        reset          = rst;
        bus.write      = w;
        bus.read       = r;
        bus.write_data = d;
        @(posedge clk);
        pre_size = model_q.size();
        if (rst) begin
            model_q.delete();
            model_rd = '0;
        end else begin
            if (r && pre_size > 0) model_rd = model_q.pop_front();
            if (w && pre_size < DEPTH) model_q.push_back(d);
        end
        #1;
        check_eq("empty", {31'd0, bus.empty}, {31'd0, model_q.size() == 0});
        check_eq("full", {31'd0, bus.full}, {31'd0, model_q.size() == DEPTH});
        check_eq("read_data", {24'd0, bus.read_data}, {24'd0, model_rd});
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        step(1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        reset          = 1'b1;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.write_data = '0;

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("rst_empty", {31'd0, bus.empty}, 32'd1);
        check_eq("rst_full", {31'd0, bus.full}, 32'd0);
        check_eq("rst_rd", {24'd0, bus.read_data}, 32'h00);

        push(8'h70);
        push(8'h71);
        pop();
        check_eq("first_pop", {24'd0, bus.read_data}, 32'h70);
        check_eq("first_pop_empty", {31'd0, bus.empty}, 32'd0);
        push(8'h72);
        pop();
        check_eq("second_pop", {24'd0, bus.read_data}, 32'h71);
        pop();
        check_eq("third_pop", {24'd0, bus.read_data}, 32'h72);
        check_eq("third_pop_empty", {31'd0, bus.empty}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            push(8'(i));
            check_eq("fill_full", {31'd0, bus.full}, (i == 7) ? 32'd1 : 32'd0);
        end
        push(8'hAA);
        check_eq("full_hold", {31'd0, bus.full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop();
            check_eq("drain_order", {24'd0, bus.read_data}, 32'(i));
        end
        check_eq("drain_empty", {31'd0, bus.empty}, 32'd1);
        pop();
        check_eq("underflow_hold", {24'd0, bus.read_data}, 32'h07);

        for (int i = 0; i < 6; i++) push(8'($urandom_range(255)));
        for (int i = 0; i < 6; i++) pop();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        check_eq("wrap_full", {31'd0, bus.full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop();
            check_eq("wrap_order", {24'd0, bus.read_data}, 32'h10 + 32'(i));
        end

        push(8'h20);
        push(8'h21);
        push(8'h22);
        step(1'b0, 1'b1, 1'b1, 8'h23);
        check_eq("rw_mid_rd", {24'd0, bus.read_data}, 32'h20);
        pop();
        pop();
        check_eq("rw_mid_not_empty", {31'd0, bus.empty}, 32'd0);
        pop();
        check_eq("rw_mid_last", {24'd0, bus.read_data}, 32'h23);
        check_eq("rw_mid_empty", {31'd0, bus.empty}, 32'd1);

        step(1'b0, 1'b1, 1'b1, 8'h33);
        check_eq("rw_empty_rd_hold", {24'd0, bus.read_data}, 32'h23);
        check_eq("rw_empty_wrote", {31'd0, bus.empty}, 32'd0);
        pop();
        check_eq("rw_empty_pop", {24'd0, bus.read_data}, 32'h33);

        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check_eq("midrst_empty", {31'd0, bus.empty}, 32'd1);
        check_eq("midrst_rd", {24'd0, bus.read_data}, 32'h00);
        push(8'h55);
        pop();
        check_eq("post_rst_pop", {24'd0, bus.read_data}, 32'h55);

        for (int i = 0; i < 3000; i++) begin
            logic rst_r;
            logic w_r;
            logic r_r;
            rst_r = ($urandom_range(99) == 0);
            w_r   = ($urandom_range(99) < ((i / 500) % 2 == 0 ? 70 : 35));
            r_r   = ($urandom_range(99) < ((i / 500) % 2 == 0 ? 35 : 70));
            step(rst_r, w_r, r_r, 8'($urandom_range(255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
